// File: rtl/rv_ctrl_pkg.sv
// Shared ALU operation codes, R-type opcode and sequencer state encoding
// for the multi-cycle R-type core control path.
package rv_ctrl_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_MUL = 4'b0110;
   localparam logic [3:0] ALU_XOR = 4'b0111;

   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] F7_BASE   = 7'h00;
   localparam logic [6:0] F7_ALT    = 7'h20;

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      DECODE    = 2'd1,
      EXECUTE   = 2'd2,
      WRITEBACK = 2'd3
   } seq_state_e;

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational R-type decoder: opcode/funct3/funct7 -> ALU select and
// an illegal flag for anything the core does not implement.
module rv_alu_decode
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_code,
   output logic       illegal
);

   always_comb begin
      alu_code = ALU_AND;
      illegal  = 1'b0;
      if (opcode != OPC_RTYPE) begin
         illegal = 1'b1;
      end else begin
         case (funct3)
            3'd0: begin
               if (funct7 == F7_BASE)     alu_code = ALU_ADD;
               else if (funct7 == F7_ALT) alu_code = ALU_SUB;
               else                       illegal  = 1'b1;
            end
            3'd1: alu_code = ALU_SLL;
            3'd2: alu_code = ALU_MUL;
            3'd3: illegal  = 1'b1;
            3'd4: alu_code = ALU_XOR;
            3'd5: alu_code = ALU_SRL;
            3'd6: alu_code = ALU_OR;
            default: alu_code = ALU_AND;
         endcase
      end
   end

endmodule

// File: rtl/rv_multicycle_sequencer.sv
// FETCH->DECODE->EXECUTE->WRITEBACK sequencer for the R-type core.
// Define RV_MUL_MULTICYCLE_EN to hold MUL in EXECUTE for MUL_CYCLES cycles.
module rv_multicycle_sequencer
   import rv_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [31:0]      instruction,
   output logic [3:0]       alu_control,
   output logic             regwrite_control,
   output logic             pc_enable,
   output logic             illegal_instr,
   output logic             busy,
   output logic [CNT_W-1:0] retired_count
);

   if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
      $error("MUL_CYCLES must be within 1..15");
   end

   seq_state_e       state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic [3:0]       alu_q, alu_d;
   logic             regwrite_q, regwrite_d;
   logic             pc_en_q, pc_en_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [3:0]       dec_alu;
   logic             dec_illegal;
   logic             unused_ir_bits;

`ifdef RV_MUL_MULTICYCLE_EN
   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
   logic [3:0] mul_cnt_q, mul_cnt_d;
`endif

   // Register and immediate fields are consumed by the datapath, not here.
   assign unused_ir_bits = ^{ir_q[24:15], ir_q[11:7]};

   rv_alu_decode u_dec (
      .opcode   (ir_q[6:0]),
      .funct3   (ir_q[14:12]),
      .funct7   (ir_q[31:25]),
      .alu_code (dec_alu),
      .illegal  (dec_illegal)
   );

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      alu_d      = alu_q;
      regwrite_d = 1'b0;
      pc_en_d    = 1'b0;
      illegal_d  = 1'b0;
      retired_d  = retired_q;
`ifdef RV_MUL_MULTICYCLE_EN
      mul_cnt_d  = mul_cnt_q;
`endif
      case (state_q)
         FETCH: begin
            if (instr_valid) begin
               ir_d    = instruction;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (dec_illegal) begin
               // Skip the instruction: PC advances, ALU select keeps its old value.
               illegal_d = 1'b1;
               pc_en_d   = 1'b1;
               state_d   = FETCH;
            end else begin
               alu_d   = dec_alu;
               state_d = EXECUTE;
`ifdef RV_MUL_MULTICYCLE_EN
               mul_cnt_d = (dec_alu == ALU_MUL) ? MUL_LOAD : 4'd0;
`endif
            end
         end
         EXECUTE: begin
`ifdef RV_MUL_MULTICYCLE_EN
            if (mul_cnt_q != 4'd0) begin
               mul_cnt_d = mul_cnt_q - 4'd1;
            end else begin
               regwrite_d = 1'b1;
               pc_en_d    = 1'b1;
               state_d    = WRITEBACK;
            end
`else
            regwrite_d = 1'b1;
            pc_en_d    = 1'b1;
            state_d    = WRITEBACK;
`endif
         end
         WRITEBACK: begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= FETCH;
         ir_q       <= '0;
         alu_q      <= ALU_AND;
         regwrite_q <= 1'b0;
         pc_en_q    <= 1'b0;
         illegal_q  <= 1'b0;
         retired_q  <= '0;
`ifdef RV_MUL_MULTICYCLE_EN
         mul_cnt_q  <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         alu_q      <= alu_d;
         regwrite_q <= regwrite_d;
         pc_en_q    <= pc_en_d;
         illegal_q  <= illegal_d;
         retired_q  <= retired_d;
`ifdef RV_MUL_MULTICYCLE_EN
         mul_cnt_q  <= mul_cnt_d;
`endif
      end
   end

   assign instr_ready      = (state_q == FETCH);
   assign busy             = (state_q != FETCH);
   assign alu_control      = alu_q;
   assign regwrite_control = regwrite_q;
   assign pc_enable        = pc_en_q;
   assign illegal_instr    = illegal_q;
   assign retired_count    = retired_q;

endmodule
